// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event stage.
package button_event_pkg;

  // FSM state: waiting for a press, held short of the long threshold, held past it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  localparam int unsigned BTN_COUNT_W = 8;

  // Larger of two cycle counts, used to size-check the hold counter.
  function automatic int unsigned btn_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/level_edge_detect.sv
// One-register edge detector for a level already synchronous to clk.
// level_q resets to 0, so a level that is high out of reset reads as a rising edge.
module level_edge_detect (
  input  logic clk,
  input  logic nreset,
  input  logic level,
  output logic level_q,
  output logic rise,
  output logic fall
);

  // Delay the level by one cycle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  // Combinational edges relative to the delayed copy.
  always_comb begin
    rise = level & ~level_q;
    fall = ~level & level_q;
  end

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into single-cycle press / release / long-press /
// auto-repeat pulses, plus a wrapping press counter. All outputs are registered.
// `release` and `repeat` are SystemVerilog keywords, so those pulses are exposed as
// release_pulse and repeat_pulse.
// Optional feature: define BUTTON_AUTO_REPEAT_EN to emit repeat_pulse while held
// past the long-press threshold; otherwise repeat_pulse is tied low.
module button_event_gen #(
  parameter int unsigned LONG_CYCLES   = 100_000_000,
  parameter int unsigned REPEAT_CYCLES = 20_000_000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       level,
  output logic       press,
  output logic       release_pulse,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  import button_event_pkg::*;

  // Refuse to elaborate if the hold counter cannot reach either threshold.
  if ((btn_max(LONG_CYCLES, REPEAT_CYCLES) >> CNT_W) != 0) begin : g_cnt_w_check
    $error("CNT_W too narrow for LONG_CYCLES/REPEAT_CYCLES");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic                   level_q;
  logic                   rise;
  logic                   fall;
  btn_state_t             state;
  logic [CNT_W-1:0]       hold_cnt;
  logic [BTN_COUNT_W-1:0] count_q;

  level_edge_detect u_edge (
    .clk     (clk),
    .nreset  (nreset),
    .level   (level),
    .level_q (level_q),
    .rise    (rise),
    .fall    (fall)
  );

  // held is the same register the edge detector compares against.
  assign held        = level_q;
  assign press_count = count_q;

  // Event FSM; every pulse defaults low so each fires for exactly one cycle.
  // fall is tested first in every held state so it wins over any threshold.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      count_q       <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (rise) begin
            press   <= 1'b1;
            count_q <= count_q + 1'b1;
            state   <= PRESSED;
          end
        end
        PRESSED: begin
          if (fall) begin
            release_pulse <= 1'b1;
            hold_cnt      <= '0;
            state         <= IDLE;
          end else if (hold_cnt == LONG_LAST) begin
            long_press <= 1'b1;
            hold_cnt   <= '0;
            state      <= LONG;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG: begin
          if (fall) begin
            release_pulse <= 1'b1;
            hold_cnt      <= '0;
            state         <= IDLE;
          end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
            if (hold_cnt == REPEAT_LAST) begin
              repeat_pulse <= 1'b1;
              hold_cnt     <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
`else
            hold_cnt <= '0;
`endif
          end
        end
        default: begin
          hold_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Repeat expectations follow BUTTON_AUTO_REPEAT_EN in the same way as the design.
module tb_button_event_gen;

  import button_event_pkg::*;

  logic       clk;
  logic       nreset;
  logic       level;
  logic       press;
  logic       release_pulse;
  logic       long_press;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] press_count;

  int checks   = 0;
  int failures = 0;

  // Per-run observations, filled by run_level.
  int press_at, release_at, long_at;
  int n_press, n_release, n_long, n_multi, held_bad;
  int rpt_at[$];

  button_event_gen #(
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .CNT_W         (4)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .press_count   (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive level high for hi cycles then low, for total cycles; sample 1 ns after each
  // rising edge. Cycle n is the sample taken after the n-th edge of the run.
  task automatic run_level(input int hi, input int total);
    press_at = -1; release_at = -1; long_at = -1;
    n_press = 0; n_release = 0; n_long = 0; n_multi = 0; held_bad = 0;
    rpt_at.delete();
    for (int n = 0; n < total; n++) begin
      @(negedge clk);
      level = (n < hi);
      @(posedge clk);
      #1;
      if (press) begin n_press++; if (press_at < 0) press_at = n; end
      if (release_pulse) begin n_release++; if (release_at < 0) release_at = n; end
      if (long_press) begin n_long++; if (long_at < 0) long_at = n; end
      if (repeat_pulse) rpt_at.push_back(n);
      if (int'(press) + int'(release_pulse) + int'(long_press) + int'(repeat_pulse) > 1)
        n_multi++;
      if (held !== (n < hi)) held_bad++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({press, release_pulse, long_press, repeat_pulse, held} !== 5'b0) begin
      failures++;
      $display("FAIL reset_pulses: got %b expected 00000",
               {press, release_pulse, long_press, repeat_pulse, held});
    end
    checks++;
    if (press_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_count: got %0d expected 0", press_count);
    end
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({press, release_pulse, long_press, repeat_pulse, held, press_count} !== 13'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got %b expected all zero",
               {press, release_pulse, long_press, repeat_pulse, held, press_count});
    end
  endtask

  task automatic test_short_press();
    run_level(3, 6);
    checks++;
    if (press_at !== 0 || n_press !== 1) begin
      failures++;
      $display("FAIL short_press: got at=%0d n=%0d expected at=0 n=1", press_at, n_press);
    end
    checks++;
    if (release_at !== 3 || n_release !== 1) begin
      failures++;
      $display("FAIL short_release: got at=%0d n=%0d expected at=3 n=1", release_at, n_release);
    end
    checks++;
    if (n_long !== 0 || rpt_at.size() !== 0) begin
      failures++;
      $display("FAIL short_no_long: got long=%0d rpt=%0d expected 0 0", n_long, rpt_at.size());
    end
    checks++;
    if (press_count !== 8'd1) begin
      failures++;
      $display("FAIL short_count: got %0d expected 1", press_count);
    end
    checks++;
    if (held_bad !== 0 || n_multi !== 0) begin
      failures++;
      $display("FAIL short_held_onehot: got held_bad=%0d multi=%0d expected 0 0",
               held_bad, n_multi);
    end
  endtask

  task automatic test_long_hold();
    run_level(20, 24);
    checks++;
    if (press_at !== 0 || long_at !== 8 || n_long !== 1) begin
      failures++;
      $display("FAIL long_press_time: got press=%0d long=%0d n=%0d expected 0 8 1",
               press_at, long_at, n_long);
    end
`ifdef BUTTON_AUTO_REPEAT_EN
    checks++;
    if (rpt_at.size() !== 2) begin
      failures++;
      $display("FAIL repeat_count: got %0d expected 2", rpt_at.size());
    end else begin
      checks++;
      if (rpt_at[0] !== 12 || rpt_at[1] !== 16) begin
        failures++;
        $display("FAIL repeat_times: got %0d,%0d expected 12,16", rpt_at[0], rpt_at[1]);
      end
    end
`else
    checks++;
    if (rpt_at.size() !== 0) begin
      failures++;
      $display("FAIL repeat_disabled: got %0d pulses expected 0", rpt_at.size());
    end
`endif
    checks++;
    if (release_at !== 20 || n_release !== 1) begin
      failures++;
      $display("FAIL long_release: got at=%0d n=%0d expected at=20 n=1", release_at, n_release);
    end
    checks++;
    if (n_multi !== 0 || held_bad !== 0 || press_count !== 8'd2) begin
      failures++;
      $display("FAIL long_misc: got multi=%0d held_bad=%0d count=%0d expected 0 0 2",
               n_multi, held_bad, press_count);
    end
  endtask

  task automatic test_simultaneous();
    run_level(8, 12);
    checks++;
    if (release_at !== 8 || n_release !== 1) begin
      failures++;
      $display("FAIL simul_release: got at=%0d n=%0d expected at=8 n=1", release_at, n_release);
    end
    checks++;
    if (n_long !== 0 || rpt_at.size() !== 0) begin
      failures++;
      $display("FAIL simul_no_long: got long=%0d rpt=%0d expected 0 0", n_long, rpt_at.size());
    end
    checks++;
    if (dut.state !== IDLE) begin
      failures++;
      $display("FAIL simul_state: got %0d expected %0d", dut.state, IDLE);
    end
    checks++;
    if (press_count !== 8'd3) begin
      failures++;
      $display("FAIL simul_count: got %0d expected 3", press_count);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    nreset = 1'b0;
    level  = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 255; i++) run_level(1, 2);
    checks++;
    if (press_count !== 8'd255) begin
      failures++;
      $display("FAIL wrap_255: got %0d expected 255", press_count);
    end
    run_level(1, 2);
    checks++;
    if (press_count !== 8'd0) begin
      failures++;
      $display("FAIL wrap_256: got %0d expected 0", press_count);
    end
    checks++;
    if (press_at !== 0 || release_at !== 1) begin
      failures++;
      $display("FAIL wrap_last_pulses: got press=%0d release=%0d expected 0 1",
               press_at, release_at);
    end
  endtask

  task automatic test_reset_mid_hold();
    run_level(30, 11);
    checks++;
    if (press_count !== 8'd1 || held !== 1'b1 || dut.state !== LONG) begin
      failures++;
      $display("FAIL midhold_pre: got count=%0d held=%0d state=%0d expected 1 1 %0d",
               press_count, held, dut.state, LONG);
    end
    #2;
    nreset = 1'b0;
    #1;
    checks++;
    if ({press, release_pulse, long_press, repeat_pulse, held, press_count} !== 13'b0) begin
      failures++;
      $display("FAIL midhold_async_reset: got %b expected all zero",
               {press, release_pulse, long_press, repeat_pulse, held, press_count});
    end
    @(posedge clk);
    #1;
    checks++;
    if (release_pulse !== 1'b0 || dut.state !== IDLE) begin
      failures++;
      $display("FAIL midhold_no_release: got release=%0d state=%0d expected 0 %0d",
               release_pulse, dut.state, IDLE);
    end
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (press !== 1'b1 || held !== 1'b1 || press_count !== 8'd1) begin
      failures++;
      $display("FAIL deassert_press: got press=%0d held=%0d count=%0d expected 1 1 1",
               press, held, press_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (press !== 1'b0 || press_count !== 8'd1) begin
      failures++;
      $display("FAIL deassert_single: got press=%0d count=%0d expected 0 1",
               press, press_count);
    end
  endtask

  initial begin
    nreset = 1'b0;
    level  = 1'b0;
    test_reset();
    test_short_press();
    test_long_hold();
    test_simultaneous();
    test_wrap();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event_gen.md
# button_event_gen

Converts the debounced, active-high button level from the debouncer stage into single-cycle event pulses for the control logic: press, release, long-press and auto-repeat. It also keeps a wrapping press counter. It sits directly downstream of the debouncer, and all of its outputs are registered in the `clk` domain.

## Interface
- `LONG_CYCLES`, default 100_000_000: continuous held cycles (1 s at 100 MHz) before `long_press` fires.
- `REPEAT_CYCLES`, default 20_000_000: cycles between successive `repeat` pulses after a long press.
- `CNT_W`, default 27: hold-counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).
- `clk`  in  1  system clock; all logic is on its rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `level`  in  1  debounced button level, already synchronous to `clk`; 1 = pressed.
- `press`  out  1  one-cycle pulse on the 0->1 edge of `level`.
- `release`  out  1  one-cycle pulse on the 1->0 edge of `level`.
- `long_press`  out  1  one-cycle pulse once per press, after LONG_CYCLES held.
- `repeat`  out  1  one-cycle pulse every REPEAT_CYCLES while held after `long_press`.
- `held`  out  1  registered copy of `level`.
- `press_count`  out  8  number of presses, wrapping 255 -> 0.

## Operation
- Edge detect: `level_q` is `level` delayed by one register.
  - `rise` = `level & ~level_q`.
  - `fall` = `~level & level_q`.
- FSM states:
  - IDLE: on `rise`, pulse `press`, increment `press_count`, clear `hold_cnt`, go to PRESSED.
  - PRESSED: `hold_cnt` increments each cycle. On `fall`, pulse `release` and go to IDLE. Otherwise, when `hold_cnt == LONG_CYCLES-1`, pulse `long_press`, clear `hold_cnt` and go to LONG.
  - LONG: on `fall`, pulse `release` and go to IDLE. Otherwise, behaviour depends on AUTO_REPEAT_EN (see Configuration).
- `fall` has priority over any threshold in the same cycle: `release` fires, `long_press`/`repeat` do not, and the state goes to IDLE.
- `hold_cnt` is cleared on every entry to IDLE.
- At most one of `press`, `release`, `long_press`, `repeat` is high in any cycle.
- `press_count` wraps modulo 256 with no flag.
- A `level` already high when `nreset` deasserts counts as a press: `level_q` resets to 0, so `press` fires on the first edge.

## Timing
- Reset values: all outputs 0, `level_q` = 0, `hold_cnt` = 0, state = IDLE.
- Reset mid-operation: immediate return to IDLE with the reset values. No `release` pulse is generated.
- `press`/`release` latency: the pulse is high in the cycle after the first edge that samples the new `level`. That is the same edge at which `held` changes.
- `long_press`: asserted exactly LONG_CYCLES cycles after `press` asserts, provided `level` stays 1.
- `repeat`: the k-th pulse is asserted LONG_CYCLES + k·REPEAT_CYCLES cycles after `press`.
- Pulses are exactly one cycle wide. There is no handshake; consumers sample every cycle.

## Configuration
- Macro `BUTTON_AUTO_REPEAT_EN`.
- Defined: in LONG, `hold_cnt` counts to REPEAT_CYCLES-1, then pulses `repeat`, clears and repeats indefinitely while held.
- Undefined:
  - LONG is a plain hold state and `hold_cnt` stays 0.
  - `repeat` is tied to 0.
  - The REPEAT_CYCLES parameter is still declared but unused.

## Structure
- Package `button_event_pkg`:
  - typedef enum `btn_state_t` {IDLE, PRESSED, LONG}, 2-bit encoding.
  - `BTN_COUNT_W` = 8.
- Sub-module `level_edge_detect` (clk, nreset, level -> `level_q`, `rise`, `fall`). It is reusable by the other front-panel stages.

## Test plan
All scenarios use LONG_CYCLES=8 and REPEAT_CYCLES=4.
- Short press: `level` high for 3 cycles, then low. Expect `press` at t+1, `release` at t+4, no `long_press`, `press_count` = 1.
- Long hold, macro undefined: `level` high for 20 cycles. Expect `long_press` exactly 8 cycles after `press`, `repeat` never high, and `release` on the fall.
- Auto-repeat, macro defined: `level` high for 20 cycles. Expect `repeat` at 12 and 16 cycles after `press`, then `release` with no further `repeat`.
- Simultaneous events: `level` falls on the cycle `hold_cnt` reaches 7. Expect `release` only, no `long_press`, state IDLE.
- Wrap and reset:
  - 256 short presses give `press_count` = 0.
  - `nreset` asserted mid-hold gives all outputs 0 immediately.
  - With `level` still 1 at deassert, `press` fires on the first edge.
